// File: rtl/bmain_sram.sv
// ---------------------------------------------------------------------------
// bmain_sram -- on-chip SRAM target on the main bus.
//
// Accepts one command at a time from the bmain arbiter and serves it as a
// whole cache-line burst:
//   read  (bmain_cmd=1): BURST_LEN beats in ascending order from the line
//                        base, over sram_rvalid/bmain_rready/sram_rlast.
//   write (bmain_cmd=0): up to BURST_LEN beats over bmain_wvalid/sram_wready,
//                        ending on bmain_wlast or the last word of the line.
// Addresses outside [BASE_WORD, BASE_WORD+DEPTH_WORDS) raise sram_error,
// held until bmain_eack.
//
// Ports
//   clk_core, reset_n      core clock, synchronous active-low reset
//   bmain_cvalid/sram_cready, bmain_cmd, bmain_addr   command channel
//   sram_rvalid/bmain_rready, sram_rlast, sram_rdata  read-beat channel
//   bmain_wvalid/sram_wready, bmain_wlast, bmain_wdata, bmain_wstrb
//                                                     write-beat channel
//   sram_error/bmain_eack  access-fault channel
//
// BASE_WORD is expected to be line aligned (a multiple of BURST_LEN).
// ---------------------------------------------------------------------------
module bmain_sram #(
  parameter logic [26:0] BASE_WORD   = 27'h0,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          BURST_LEN   = 4
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        bmain_cvalid,
  output logic        sram_cready,
  input  logic        bmain_cmd,
  input  logic [26:0] bmain_addr,
  output logic        sram_rvalid,
  input  logic        bmain_rready,
  output logic        sram_rlast,
  output logic [31:0] sram_rdata,
  input  logic        bmain_wvalid,
  output logic        sram_wready,
  input  logic        bmain_wlast,
  input  logic [31:0] bmain_wdata,
  input  logic [3:0]  bmain_wstrb,
  output logic        sram_error,
  input  logic        bmain_eack
);

  localparam int               IDX_W    = $clog2(DEPTH_WORDS);
  localparam int               CNT_W    = $clog2(BURST_LEN);
  localparam logic [26:0]      DEPTH_27 = 27'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    RD   = 4'b0010,
    WR   = 4'b0100,
    ERR  = 4'b1000
  } state_t;

  state_t state, state_nxt;

  logic [31:0]            mem [DEPTH_WORDS];
  logic [IDX_W-CNT_W-1:0] line_sel;
  logic [CNT_W-1:0]       cnt;
  logic                   rd_done;
  logic                   rd_vld_p1;
  logic                   rd_last_p1;
  logic [31:0]            rd_data_p1;

  logic [26:0]            off;
  logic                   in_range;
  logic                   cmd_hs;
  logic                   rd_issue;
  logic                   wr_beat;
  logic [IDX_W-1:0]       word_idx;

  // Unsigned difference; an address below BASE_WORD wraps to a huge offset,
  // and the explicit >= test rejects it even if the wrap lands in range.
  assign off      = bmain_addr - BASE_WORD;
  assign in_range = (bmain_addr >= BASE_WORD) && (off < DEPTH_27);
  assign cmd_hs   = bmain_cvalid & sram_cready;
  assign word_idx = {line_sel, cnt};

  assign sram_rvalid = rd_vld_p1;
  assign sram_rlast  = rd_last_p1;
  assign sram_rdata  = rd_data_p1;

  always_ff @(posedge clk_core) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    sram_cready = 1'b0;
    sram_wready = 1'b0;
    sram_error  = 1'b0;
    rd_issue    = 1'b0;
    wr_beat     = 1'b0;
    case (state)
      IDLE: begin
        // Held low while reset is asserted so nothing is accepted then.
        sram_cready = reset_n;
        if (cmd_hs) begin
          if (!in_range)      state_nxt = ERR;
          else if (bmain_cmd) state_nxt = RD;
          else                state_nxt = WR;
        end
      end
      RD: begin
        // Refill the output register whenever it is empty or draining.
        rd_issue = ~rd_done & (~rd_vld_p1 | bmain_rready);
        if (rd_vld_p1 & bmain_rready & rd_last_p1) state_nxt = IDLE;
      end
      WR: begin
        // Gated by reset so an aborted burst writes no further beat.
        sram_wready = reset_n;
        wr_beat     = bmain_wvalid & reset_n;
        if (wr_beat & (bmain_wlast | (cnt == CNT_LAST))) state_nxt = IDLE;
      end
      ERR: begin
        sram_error = 1'b1;
        if (bmain_eack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter and read-output control
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      cnt        <= '0;
      rd_done    <= 1'b0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
    end else begin
      if (cmd_hs) begin
        cnt     <= '0;
        rd_done <= 1'b0;
      end else if (rd_issue || wr_beat) begin
        cnt <= cnt + 1'b1;
        if (rd_issue && (cnt == CNT_LAST)) rd_done <= 1'b1;
      end
      if (rd_issue) begin
        rd_vld_p1  <= 1'b1;
        rd_last_p1 <= (cnt == CNT_LAST);
      end else if (rd_vld_p1 && bmain_rready) begin
        rd_vld_p1  <= 1'b0;
        rd_last_p1 <= 1'b0;
      end
    end
  end

  // Line latch and SRAM array (data only, never reset)
  always_ff @(posedge clk_core) begin
    if (cmd_hs) line_sel <= off[IDX_W-1:CNT_W];
    if (rd_issue) rd_data_p1 <= mem[word_idx];
    if (wr_beat) begin
      for (int b = 0; b < 4; b++) begin
        if (bmain_wstrb[b]) mem[word_idx][8*b +: 8] <= bmain_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bmain_sram.sv
module tb_bmain_sram;

  localparam logic [26:0] BASE  = 27'h1000;
  localparam int          DEPTH = 4096;
  localparam int          BL    = 4;

  logic        clk_core = 1'b0;
  logic        reset_n;
  logic        bmain_cvalid, bmain_cmd;
  logic [26:0] bmain_addr;
  logic        sram_cready, sram_rvalid, sram_rlast, sram_wready, sram_error;
  logic [31:0] sram_rdata;
  logic        bmain_rready, bmain_wvalid, bmain_wlast, bmain_eack;
  logic [31:0] bmain_wdata;
  logic [3:0]  bmain_wstrb;

  int checks = 0;
  int errs   = 0;

  // Behavioural picture of the SRAM, indexed by word offset from BASE.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd [BL];
  logic [3:0]  ws [BL];
  logic [6:0]  rr_pat = 7'b1101001;  // bit i = rready in i-th cycle after first beat

  bmain_sram #(.BASE_WORD(BASE), .DEPTH_WORDS(DEPTH), .BURST_LEN(BL)) dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .bmain_cvalid(bmain_cvalid), .sram_cready(sram_cready),
    .bmain_cmd(bmain_cmd), .bmain_addr(bmain_addr),
    .sram_rvalid(sram_rvalid), .bmain_rready(bmain_rready),
    .sram_rlast(sram_rlast), .sram_rdata(sram_rdata),
    .bmain_wvalid(bmain_wvalid), .sram_wready(sram_wready),
    .bmain_wlast(bmain_wlast), .bmain_wdata(bmain_wdata), .bmain_wstrb(bmain_wstrb),
    .sram_error(sram_error), .bmain_eack(bmain_eack)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int line_of(input logic [26:0] a);
    return int'(a - BASE) & ~(BL - 1);
  endfunction

  // All tasks start and end on a falling edge with the DUT idle.
  task automatic do_write(input logic [26:0] a, input int nb, input bit last_flag,
                          input bit gaps);
    int lo, beat, cyc;
    lo = line_of(a);
    bmain_cvalid = 1'b1; bmain_cmd = 1'b0; bmain_addr = a;
    chk("wr_cready", 32'(sram_cready), 32'd1);
    @(negedge clk_core);
    bmain_cvalid = 1'b0;
    beat = 0; cyc = 0;
    while (beat < nb && cyc < 100) begin
      chk("wr_wready", 32'(sram_wready), 32'd1);
      if (gaps && $urandom_range(0, 3) == 0) begin
        bmain_wvalid = 1'b0;
      end else begin
        bmain_wvalid = 1'b1;
        bmain_wdata  = wd[beat];
        bmain_wstrb  = ws[beat];
        bmain_wlast  = last_flag && (beat == nb - 1);
        ref_mem[lo + beat] = merge(ref_mem[lo + beat], wd[beat], ws[beat]);
        beat++;
      end
      @(negedge clk_core);
      cyc++;
    end
    bmain_wvalid = 1'b0; bmain_wlast = 1'b0;
    chk("wr_end_wready", 32'(sram_wready), 32'd0);
    chk("wr_end_cready", 32'(sram_cready), 32'd1);
  endtask

  // mode 0: rready always 1 (latency checked), 1: rr_pat, 2: random
  task automatic do_read(input logic [26:0] a, input int mode, input bit hold,
                         input logic [26:0] next_a);
    int lo, beat, cyc, first_cyc, last_cyc, pidx;
    bit rr;
    lo = line_of(a);
    bmain_cvalid = 1'b1; bmain_cmd = 1'b1; bmain_addr = a; bmain_rready = 1'b0;
    chk("rd_cready", 32'(sram_cready), 32'd1);
    @(negedge clk_core);
    cyc = 1;
    if (hold) begin bmain_cmd = 1'b0; bmain_addr = next_a; end
    else bmain_cvalid = 1'b0;
    chk("rd_t1_rvalid", 32'(sram_rvalid), 32'd0);
    beat = 0; first_cyc = -1; last_cyc = -1; pidx = 0;
    while (beat < BL && cyc < 200) begin
      if (hold) chk("hold_cready", 32'(sram_cready), 32'd0);
      if (sram_rvalid) begin
        if (first_cyc < 0) first_cyc = cyc;
        chk("rd_data", sram_rdata, ref_mem[lo + beat]);
        chk("rd_last", 32'(sram_rlast), 32'(beat == BL - 1));
      end
      if (mode == 0) rr = 1'b1;
      else if (mode == 1) begin
        if (first_cyc < 0) rr = 1'b0;
        else begin
          rr = (pidx < 7) ? rr_pat[pidx] : 1'b1;
          pidx++;
        end
      end else rr = ($urandom_range(0, 2) != 0);
      bmain_rready = rr;
      if (sram_rvalid && rr) begin
        if (beat == BL - 1) last_cyc = cyc;
        beat++;
      end
      @(negedge clk_core);
      cyc++;
    end
    bmain_rready = 1'b0;
    chk("rd_beats", 32'(beat), 32'(BL));
    chk("rd_end_rvalid", 32'(sram_rvalid), 32'd0);
    chk("rd_end_cready", 32'(sram_cready), 32'd1);
    if (mode == 0) begin
      chk("rd_first_lat", 32'(first_cyc), 32'd2);
      chk("rd_last_lat", 32'(last_cyc), 32'(2 + BL - 1));
    end
  endtask

  task automatic do_err(input logic [26:0] a, input bit cmd_v, input int hold_cycles);
    bmain_cvalid = 1'b1; bmain_cmd = cmd_v; bmain_addr = a;
    chk("err_cmd_cready", 32'(sram_cready), 32'd1);
    @(negedge clk_core);
    bmain_cvalid = 1'b0;
    // Stray traffic while faulted must neither write nor produce beats.
    bmain_wvalid = 1'b1; bmain_wdata = $urandom; bmain_wstrb = 4'hF; bmain_rready = 1'b1;
    for (int i = 0; i < hold_cycles; i++) begin
      chk("err_hold", 32'(sram_error), 32'd1);
      chk("err_cready", 32'(sram_cready), 32'd0);
      chk("err_wready", 32'(sram_wready), 32'd0);
      chk("err_rvalid", 32'(sram_rvalid), 32'd0);
      @(negedge clk_core);
    end
    bmain_eack = 1'b1;
    chk("err_at_eack", 32'(sram_error), 32'd1);
    @(negedge clk_core);
    bmain_eack = 1'b0; bmain_wvalid = 1'b0; bmain_rready = 1'b0;
    chk("err_cleared", 32'(sram_error), 32'd0);
    chk("err_end_cready", 32'(sram_cready), 32'd1);
  endtask

  task automatic rand_line(input bit full_strb);
    for (int i = 0; i < BL; i++) begin
      wd[i] = $urandom;
      ws[i] = full_strb ? 4'hF : 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [26:0] a;
    int nb, op;
    reset_n = 1'b0; bmain_cvalid = 1'b0; bmain_cmd = 1'b0; bmain_addr = '0;
    bmain_rready = 1'b0; bmain_wvalid = 1'b0; bmain_wlast = 1'b0;
    bmain_wdata = '0; bmain_wstrb = '0; bmain_eack = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk_core);
    chk("rst_cready", 32'(sram_cready), 32'd0);
    chk("rst_rvalid", 32'(sram_rvalid), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_core);
    chk("post_rst_cready", 32'(sram_cready), 32'd1);
    chk("post_rst_rvalid", 32'(sram_rvalid), 32'd0);
    chk("post_rst_rlast", 32'(sram_rlast), 32'd0);
    chk("post_rst_wready", 32'(sram_wready), 32'd0);
    chk("post_rst_error", 32'(sram_error), 32'd0);

    // Preload line 0x100 and read from mid-line: ascending from line base
    for (int i = 0; i < BL; i++) begin wd[i] = 32'hA000_0000 + 32'(i); ws[i] = 4'hF; end
    do_write(BASE + 27'h100, BL, 1'b1, 1'b0);
    do_read(BASE + 27'h102, 0, 1'b0, '0);
    do_read(BASE + 27'h102, 1, 1'b0, '0);

    // Full write, read back, then one partial-strobe beat
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wd[2] = 32'h3333_3333; wd[3] = 32'h4444_4444;
    for (int i = 0; i < BL; i++) ws[i] = 4'hF;
    do_write(BASE + 27'h200, BL, 1'b1, 1'b0);
    do_read(BASE + 27'h200, 0, 1'b0, '0);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'h3;
    do_write(BASE + 27'h200, 1, 1'b1, 1'b0);
    do_read(BASE + 27'h200, 0, 1'b0, '0);

    // Write ended by the beat counter; a following stray beat is ignored
    rand_line(1'b1);
    do_write(BASE + 27'h280, BL, 1'b0, 1'b0);
    bmain_wvalid = 1'b1; bmain_wdata = 32'hDEAD_BEEF; bmain_wstrb = 4'hF;
    chk("stray_wready", 32'(sram_wready), 32'd0);
    @(negedge clk_core);
    bmain_wvalid = 1'b0;
    do_read(BASE + 27'h280, 0, 1'b0, '0);

    // Out-of-range accesses
    do_err(BASE + 27'(DEPTH), 1'b1, 3);
    do_err(BASE - 27'd1, 1'b1, 1);
    do_err(27'h7FF_FFFF, 1'b0, 2);
    do_read(BASE + 27'h200, 0, 1'b0, '0);

    // Reset during the second beat of a read
    rand_line(1'b1);
    do_write(BASE + 27'h300, BL, 1'b1, 1'b0);
    bmain_cvalid = 1'b1; bmain_cmd = 1'b1; bmain_addr = BASE + 27'h300;
    @(negedge clk_core);
    bmain_cvalid = 1'b0; bmain_rready = 1'b1;
    @(negedge clk_core);
    @(negedge clk_core);
    chk("rst_mid_beat1", sram_rdata, ref_mem[12'h301]);
    reset_n = 1'b0;
    @(negedge clk_core);
    chk("rst_mid_rvalid", 32'(sram_rvalid), 32'd0);
    chk("rst_mid_cready", 32'(sram_cready), 32'd0);
    reset_n = 1'b1; bmain_rready = 1'b0;
    @(negedge clk_core);
    chk("rst_mid_idle", 32'(sram_cready), 32'd1);
    chk("rst_mid_rlast", 32'(sram_rlast), 32'd0);
    do_read(BASE + 27'h300, 0, 1'b0, '0);

    // Back-to-back commands with cvalid held: write waits for the burst end
    rand_line(1'b1);
    do_read(BASE + 27'h100, 0, 1'b1, BASE + 27'h104);
    do_write(BASE + 27'h104, BL, 1'b1, 1'b0);
    do_read(BASE + 27'h104, 2, 1'b0, '0);

    // Randomised traffic over lines 0..15
    for (int l = 0; l < 16; l++) begin
      rand_line(1'b1);
      do_write(BASE + 27'(l * BL), BL, 1'b1, 1'b1);
    end
    for (int it = 0; it < 60; it++) begin
      a  = BASE + 27'($urandom_range(0, 63));
      op = $urandom_range(0, 9);
      if (op < 5) begin
        do_read(a, $urandom_range(0, 2), 1'b0, '0);
      end else if (op < 9) begin
        nb = $urandom_range(1, BL);
        rand_line(1'b0);
        do_write(a, nb, (nb < BL) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1);
      end else begin
        do_err(BASE + 27'(DEPTH) + 27'($urandom_range(0, 1000)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
